inst_ram_loader: RTL and testbench

- Boot/programming controller for the CPU's instruction RAM.
- Receives a byte stream through a valid/ready handshake, typically from a UART receiver, and assembles little-endian 32-bit words.
- Writes each word through the CPU's inst_ram_write_* port while holding the CPU in reset and debug.
- After the last word it waits a programmable hold time, then releases cpu_reset and debug. This replaces the hand-sequenced load-then-release stimulus in simulation and on the board.

---
 rtl/inst_loader_pkg.sv | 36 +++
 rtl/inst_ram_loader_timeout.sv | 40 ++++
 rtl/inst_ram_loader.sv | 189 ++++++++++++++++++
 tb/tb_inst_ram_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// -----------------------------------------------------------------------------
// inst_loader_pkg
//   Shared types and constants for the instruction-RAM boot loader.
//   - loader_state_e : loader FSM states
//   - HDR_BYTES      : bytes in the little-endian word-count header
//   - WORD_BYTES     : bytes per instruction word
//   - accepts_bytes  : states in which the loader raises in_ready
//   - is_busy        : states that count as "loading" (header through hold)
// -----------------------------------------------------------------------------
package inst_loader_pkg;

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_HOLD  = 3'd4,
        S_RUN   = 3'd5,
        S_ERROR = 3'd6
    } loader_state_e;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int COUNT_W    = 8 * HDR_BYTES;
    localparam int WORD_W     = 8 * WORD_BYTES;
    localparam int BIDX_W     = $clog2(WORD_BYTES);

    function automatic logic accepts_bytes(input loader_state_e s);
        return s inside {S_HDR0, S_HDR1, S_DATA};
    endfunction

    function automatic logic is_busy(input loader_state_e s);
        return s inside {S_HDR0, S_HDR1, S_DATA, S_WRITE, S_HOLD};
    endfunction

endpackage

// File: rtl/inst_ram_loader_timeout.sv
// -----------------------------------------------------------------------------
// loader_timeout
//   Saturating inter-byte gap counter.
//   Ports:
//     clk, reset   : clock, async active-high reset
//     i_clear      : restart the gap (byte accepted / not in a timed state)
//     i_enable     : count this cycle
//     o_expired    : this cycle is the TIMEOUT_CYCLES-th idle cycle in a row
// -----------------------------------------------------------------------------
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    // Count value held during the last permitted idle cycle.
    localparam int unsigned LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int          CNT_W = (LAST < 2) ? 1 : $clog2(LAST + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != CNT_W'(LAST))) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Flagged one cycle early so the FSM lands in ERROR exactly
    // TIMEOUT_CYCLES edges after the last accepted byte.
    assign o_expired = i_enable && !i_clear && (r_cnt == CNT_W'(LAST));

endmodule

// File: rtl/inst_ram_loader.sv
// -----------------------------------------------------------------------------
// inst_ram_loader
//   Boot controller for the CPU instruction RAM. Takes a byte stream
//   (N[7:0], N[15:8], then N little-endian 32-bit words), writes each word
//   through the inst_ram_write_* port while holding the CPU in reset/debug,
//   waits HOLD_CYCLES, then releases the CPU.
//   Ports:
//     clk, reset              : clock, async active-high reset
//     load_start              : pulse, restarts loading from any state
//     in_valid/in_data/in_ready : byte stream handshake
//     inst_ram_write_*        : one-cycle write strobe, word data, word address
//     cpu_reset, debug        : high whenever the CPU is not running
//     busy, done, error       : loading / running / failed status
// -----------------------------------------------------------------------------
module inst_ram_loader
    import inst_loader_pkg::*;
#(
    parameter int          ADDR_W         = 16,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned HOLD_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              inst_ram_write_enable,
    output logic [WORD_W-1:0] inst_ram_write_data,
    output logic [ADDR_W-1:0] inst_ram_write_address,
    output logic              cpu_reset,
    output logic              debug,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned   HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam [ADDR_W-1:0]   BASE      = ADDR_W'(BASE_ADDR);

    loader_state_e       r_state;
    loader_state_e       w_next;
    logic [COUNT_W-1:0]  r_count;      // N from the header
    logic [COUNT_W-1:0]  r_words;      // words written so far
    logic [BIDX_W-1:0]   r_byte_idx;   // byte position within current word
    logic [WORD_W-1:0]   r_word;       // shift register, doubles as write data
    logic [31:0]         r_hold_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_in_ready;
    logic                r_we;
    logic                r_cpu_reset;
    logic                r_debug;
    logic                r_busy;
    logic                r_done;
    logic                r_error;

    logic                w_accept;
    logic [COUNT_W-1:0]  w_hdr_n;
    logic                w_tmo_en;
    logic                w_tmo_clear;
    logic                w_expired;
    logic                w_last_byte;
    logic                w_last_word;

    assign w_accept    = in_valid && r_in_ready;
    assign w_hdr_n     = {in_data, r_count[7:0]};
    assign w_tmo_en    = (r_state == S_HDR1) || (r_state == S_DATA);
    // Clearing whenever not in a timed state makes every entry start at zero.
    assign w_tmo_clear = w_accept || !w_tmo_en;
    assign w_last_byte = (r_byte_idx == BIDX_W'(WORD_BYTES - 1));
    assign w_last_word = ((r_words + COUNT_W'(1)) == r_count);

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_tmo_clear),
        .i_enable (w_tmo_en),
        .o_expired(w_expired)
    );

    always_comb begin
        w_next = r_state;
        if (load_start) begin
            // Wins over a coincident byte; a WRITE in progress has already
            // strobed this cycle, so it completes regardless.
            w_next = S_HDR0;
        end else begin
            unique case (r_state)
                S_HDR0: if (w_accept) w_next = S_HDR1;
                S_HDR1: begin
                    if (w_accept) begin
                        if (w_hdr_n == '0)               w_next = S_HOLD;
                        else if (32'(w_hdr_n) > DEPTH)   w_next = S_ERROR;
                        else                             w_next = S_DATA;
                    end else if (w_expired) begin
                        w_next = S_ERROR;
                    end
                end
                S_DATA: begin
                    if (w_accept && w_last_byte) w_next = S_WRITE;
                    else if (w_expired)          w_next = S_ERROR;
                end
                S_WRITE: w_next = w_last_word ? S_HOLD : S_DATA;
                S_HOLD:  if (r_hold_cnt == HOLD_LAST) w_next = S_RUN;
                S_RUN:   w_next = S_RUN;
                S_ERROR: w_next = S_ERROR;
                default: w_next = S_HDR0;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_HDR0;
            r_count     <= '0;
            r_words     <= '0;
            r_byte_idx  <= '0;
            r_word      <= '0;
            r_hold_cnt  <= '0;
            r_addr      <= BASE;
            r_in_ready  <= 1'b1;
            r_we        <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_debug     <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= accepts_bytes(w_next);
            r_we        <= (w_next == S_WRITE);
            r_cpu_reset <= (w_next != S_RUN);
            r_debug     <= (w_next != S_RUN);
            r_busy      <= is_busy(w_next);
            r_done      <= (w_next == S_RUN);
            r_error     <= (w_next == S_ERROR);

            if (load_start) begin
                // Partial word dropped; RAM contents are left as written.
                r_count    <= '0;
                r_words    <= '0;
                r_byte_idx <= '0;
                r_word     <= '0;
                r_hold_cnt <= '0;
                r_addr     <= BASE;
            end else begin
                unique case (r_state)
                    S_HDR0: if (w_accept) r_count[7:0] <= in_data;
                    S_HDR1: begin
                        if (w_accept) begin
                            r_count    <= w_hdr_n;
                            r_words    <= '0;
                            r_byte_idx <= '0;
                        end
                    end
                    S_DATA: begin
                        if (w_accept) begin
                            // Little-endian: after four shifts byte 0 sits in [7:0].
                            r_word     <= {in_data, r_word[WORD_W-1:8]};
                            r_byte_idx <= r_byte_idx + BIDX_W'(1);
                        end
                    end
                    S_WRITE: begin
                        r_words <= r_words + COUNT_W'(1);
                        r_addr  <= r_addr + ADDR_W'(1);
                    end
                    S_HOLD:  r_hold_cnt <= r_hold_cnt + 32'd1;
                    default: ;
                endcase
            end
        end
    end

    assign in_ready               = r_in_ready;
    assign inst_ram_write_enable  = r_we;
    assign inst_ram_write_data    = r_word;
    assign inst_ram_write_address = r_addr;
    assign cpu_reset              = r_cpu_reset;
    assign debug                  = r_debug;
    assign busy                   = r_busy;
    assign done                   = r_done;
    assign error                  = r_error;

endmodule

// File: tb/tb_inst_ram_loader.sv
module tb_inst_ram_loader;

    localparam int ADDR_W = 16;
    localparam int BASE   = 0;
    localparam int DEPTH  = 1024;
    localparam int HOLD   = 4;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load_start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              inst_ram_write_enable;
    logic [31:0]       inst_ram_write_data;
    logic [ADDR_W-1:0] inst_ram_write_address;
    logic              cpu_reset, debug, busy, done, error;

    inst_ram_loader #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH),
        .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .inst_ram_write_enable(inst_ram_write_enable),
        .inst_ram_write_data(inst_ram_write_data),
        .inst_ram_write_address(inst_ram_write_address),
        .cpu_reset(cpu_reset), .debug(debug), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; int cyc; } wr_t;
    wr_t wq[$];
    int  cyc = 0;
    int  fall_cyc = 0;
    int  errors = 0;
    int  checks = 0;
    logic prev_we = 1'b0;
    logic prev_rst = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: logs every strobe and checks handshake rules around it.
    always @(negedge clk) begin
        if (inst_ram_write_enable === 1'b1) begin
            wq.push_back('{inst_ram_write_address, inst_ram_write_data, cyc});
            chk("ready_low_in_write", 32'(in_ready), 32'd0);
            chk("strobe_single_cycle", 32'(prev_we), 32'd0);
        end
        if (prev_rst === 1'b1 && cpu_reset === 1'b0) fall_cyc <= cyc;
        prev_we  <= inst_ram_write_enable;
        prev_rst <= cpu_reset;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_wait", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse_start;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic wait_end;
        int n;
        n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("end_reached", 32'(done | error), 32'd1);
        @(negedge clk);
    endtask

    typedef struct {
        string        name;
        int           nb;
        logic [207:0] b;   // byte 0 in the most significant used position
        int           nw;
        logic [191:0] w;   // word 0 in the most significant used position
        bit           err;
    } vec_t;
    vec_t tv[4];

    logic [7:0]  q[$];
    logic [207:0] bv;
    logic [191:0] wv;
    logic [15:0] n_hdr;
    logic [31:0] exp_w;
    int          base, k, nexp;
    bit          exp_err;

    initial begin
        tv[0] = '{"prog", 26,
                  {8'h06,8'h00, 8'h01,8'h00,8'h00,8'h00, 8'h30,8'h01,8'h0F,8'h00,
                   8'h30,8'h01,8'hAB,8'h00, 8'h01,8'h10,8'h00,8'h00,
                   8'h20,8'h08,8'h01,8'h00, 8'h04,8'h10,8'h42,8'h05},
                  6,
                  {32'h00000001, 32'h000F0130, 32'h00AB0130,
                   32'h00001001, 32'h00010820, 32'h05421004},
                  1'b0};
        tv[1] = '{"reload", 6, 208'({8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE}),
                  1, 192'(32'hDEADBEEF), 1'b0};
        tv[2] = '{"empty", 2, 208'({8'h00,8'h00}), 0, '0, 1'b0};
        tv[3] = '{"oversize", 2, 208'({8'h01,8'h04}), 0, '0, 1'b1};

        // Reset state
        idle(2);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_debug", 32'(debug), 32'd1);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_we", 32'(inst_ram_write_enable), 32'd0);
        chk("rst_data", inst_ram_write_data, 32'd0);
        chk("rst_addr", 32'(inst_ram_write_address), 32'(BASE));
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        idle(1);
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // Table-driven streams (continuous in_valid)
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                pulse_start;
                chk({tv[i].name, "_start_cpu_reset"}, 32'(cpu_reset), 32'd1);
                chk({tv[i].name, "_start_done"}, 32'(done), 32'd0);
                chk({tv[i].name, "_start_error"}, 32'(error), 32'd0);
                chk({tv[i].name, "_start_ready"}, 32'(in_ready), 32'd1);
            end
            base = wq.size();
            bv = tv[i].b;
            wv = tv[i].w;
            for (int j = 0; j < tv[i].nb; j++) send_byte(bv[8*(tv[i].nb-1-j) +: 8]);
            wait_end;
            chk({tv[i].name, "_nwrites"}, 32'(wq.size() - base), 32'(tv[i].nw));
            for (int j = 0; j < tv[i].nw; j++) begin
                if (base + j < wq.size()) begin
                    chk({tv[i].name, "_addr"}, 32'(wq[base+j].addr), 32'(BASE + j));
                    chk({tv[i].name, "_data"}, wq[base+j].data, wv[32*(tv[i].nw-1-j) +: 32]);
                end
            end
            for (int j = 1; j < tv[i].nw; j++) begin
                if (base + j < wq.size())
                    chk({tv[i].name, "_write_spacing"},
                        32'(wq[base+j].cyc - wq[base+j-1].cyc), 32'd5);
            end
            chk({tv[i].name, "_error"}, 32'(error), 32'(tv[i].err));
            chk({tv[i].name, "_done"}, 32'(done), 32'(!tv[i].err));
            chk({tv[i].name, "_cpu_reset"}, 32'(cpu_reset), 32'(tv[i].err));
            chk({tv[i].name, "_debug"}, 32'(debug), 32'(tv[i].err));
            if (tv[i].err) begin
                chk({tv[i].name, "_busy"}, 32'(busy), 32'd0);
                chk({tv[i].name, "_ready"}, 32'(in_ready), 32'd0);
            end
            if (!tv[i].err && tv[i].nw > 0 && wq.size() > 0)
                chk({tv[i].name, "_hold_cycles"},
                    32'(fall_cyc - wq[wq.size()-1].cyc - 1), 32'(HOLD));
        end

        // Leave ERROR via load_start; HDR0 must never time out.
        pulse_start;
        chk("err_clear", 32'(error), 32'd0);
        idle(3 * TMO);
        chk("hdr0_no_timeout", 32'(error), 32'd0);
        chk("hdr0_ready", 32'(in_ready), 32'd1);

        // Gap timeout after a partial word
        base = wq.size();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'hAA);
        k = 0;
        while (error !== 1'b1 && k < 3 * TMO) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_cycles", 32'(k), 32'(TMO));
        chk("timeout_no_write", 32'(wq.size() - base), 32'd0);
        chk("timeout_cpu_reset", 32'(cpu_reset), 32'd1);

        // N == DEPTH is legal
        pulse_start;
        send_byte(8'h00); send_byte(8'h04);
        chk("depth_ok_error", 32'(error), 32'd0);
        chk("depth_ok_ready", 32'(in_ready), 32'd1);

        // load_start with a coincident byte: byte dropped
        pulse_start;
        base = wq.size();
        load_start = 1'b1; in_valid = 1'b1; in_data = 8'h07;
        @(negedge clk);
        load_start = 1'b0; in_valid = 1'b0;
        chk("drop_ready", 32'(in_ready), 32'd1);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        wait_end;
        chk("drop_nwrites", 32'(wq.size() - base), 32'd1);
        if (wq.size() > base) chk("drop_data", wq[base].data, 32'h12345678);
        chk("drop_done", 32'(done), 32'd1);

        // load_start during WRITE: strobe completes, then back to HDR0
        pulse_start;
        base = wq.size();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        chk("wr_abort_we", 32'(inst_ram_write_enable), 32'd1);
        pulse_start;
        chk("wr_abort_we_off", 32'(inst_ram_write_enable), 32'd0);
        chk("wr_abort_ready", 32'(in_ready), 32'd1);
        chk("wr_abort_busy", 32'(busy), 32'd1);
        chk("wr_abort_addr", 32'(inst_ram_write_address), 32'(BASE));
        chk("wr_abort_nwrites", 32'(wq.size() - base), 32'd1);
        if (wq.size() > base) chk("wr_abort_data", wq[base].data, 32'h44332211);

        // Randomized streams with random gaps against a stream-level model
        for (int it = 0; it < 8; it++) begin
            pulse_start;
            base = wq.size();
            n_hdr = (it == 5) ? 16'(DEPTH + 1 + $urandom_range(0, 100))
                              : 16'($urandom_range(0, 6));
            q.delete();
            q.push_back(n_hdr[7:0]);
            q.push_back(n_hdr[15:8]);
            exp_err = (int'(n_hdr) > DEPTH);
            if (!exp_err)
                for (int j = 0; j < 4 * int'(n_hdr); j++) q.push_back(8'($urandom_range(0, 255)));
            foreach (q[j]) begin
                in_valid = 1'b0;
                idle($urandom_range(0, 3));
                send_byte(q[j]);
            end
            wait_end;
            nexp = exp_err ? 0 : int'(n_hdr);
            chk("rnd_nwrites", 32'(wq.size() - base), 32'(nexp));
            for (int w = 0; w < nexp; w++) begin
                exp_w = 32'(q[2+4*w]) + (32'(q[3+4*w]) << 8)
                      + (32'(q[4+4*w]) << 16) + (32'(q[5+4*w]) << 24);
                if (base + w < wq.size()) begin
                    chk("rnd_addr", 32'(wq[base+w].addr), 32'((BASE + w) % (1 << ADDR_W)));
                    chk("rnd_data", wq[base+w].data, exp_w);
                end
            end
            chk("rnd_error", 32'(error), 32'(exp_err));
            chk("rnd_done", 32'(done), 32'(!exp_err));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
